mult_div_unit: RTL
==================

# mult_div_unit

Parametrised multi-cycle multiply/divide unit with HI/LO registers, sitting in the E stage of the pipelined CPU beside the ALU. It supersedes the fixed 32-bit unit: operand width and per-operation latency are parameters, and it adds a flush input for cancelling an in-flight operation, defined divide-by-zero and overflow results, and optional multiply-accumulate ops. The hazard unit stalls D on `start | busy` for any HI/LO-using instruction.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_LAT, 5, cycles from accepted multiply/MADD/MSUB start to result; range 1 to 255.
- DIV_LAT, 10, cycles from accepted divide start to result; range 1 to 255.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  launch `op` this cycle.
- op  in  3  operation code, defined in `mdu_pkg`.
- d1  in  WIDTH  operand A (rs); also the write data for HI/LO.
- d2  in  WIDTH  operand B (rt).
- hi_write  in  1  mthi: HI <= d1.
- lo_write  in  1  mtlo: LO <= d1.
- flush  in  1  cancel any in-flight operation.
- busy  out  1  registered; high while an operation is in flight.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- Op codes:
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
  - 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
- Multiply: {HI,LO} <= 2·WIDTH-bit product. Signed ops use signed operands; unsigned ops use unsigned operands.
- MADD/MSUB: {HI,LO} <= {HI,LO} ± product. The accumulate base is the HI/LO value at the cycle of start. The 2·WIDTH-bit sum wraps.
- Divide:
  - LO <= quotient, truncated toward zero.
  - HI <= remainder, with the sign of the dividend.
- Divide by zero (d2==0): the operation still runs DIV_LAT cycles and busy behaves normally. HI/LO are left unchanged at completion.
- Signed overflow (DIV of min-int by −1): LO <= min-int, HI <= 0.
- The result is computed at acceptance and held in pending registers. A down-counter loaded with the latency commits the pending values when it expires.
- Acceptance rules:
  - start is accepted only when busy==0 and flush==0.
  - start while busy is ignored. This is a hazard-unit bug; a simulation assertion fires.
- hi_write/lo_write are honoured only when busy==0 and start==0.
  - start has priority over them in the same cycle.
  - hi_write and lo_write together write both registers.
- flush:
  - Clears the counter and busy at the next edge.
  - Discards the pending result; HI/LO keep their pre-operation values.
  - flush on the completing cycle (counter==1) wins: no commit.
- States:
  - IDLE --accepted start--> RUN(n=LAT).
  - RUN(n>1) --> RUN(n−1).
  - RUN(1) --> IDLE, committing the result.
  - Any state --flush or reset--> IDLE.
- Reset: hi=0, lo=0, busy=0, counter=0, pending registers=0.

## Timing
- start accepted at edge t:
  - busy is 1 for edges t+1 … t+LAT−1.
  - busy is 0 after edge t+LAT.
  - hi/lo show the new value after edge t+LAT, in the same cycle busy drops.
- LAT=1: busy never rises; the result appears after edge t+1.
- hi_write/lo_write: the value is visible after the next edge.
- A new start is accepted in the same cycle busy is first seen low, giving back-to-back operations with no bubble.
- reset asserted mid-operation aborts it; outputs hold their reset values from the next edge.

## Configuration
- MDU_MADD_EN defined: op codes 4–7 are implemented as specified above, with latency MULT_LAT.
- MDU_MADD_EN undefined: op codes 4–7 are not implemented.
  - start with op 4–7 is a no-op: busy does not rise and HI/LO are unchanged.
  - The accumulate adder is not synthesised.

## Structure
- `mdu_pkg` holds:
  - op code constants MDU_MULT … MDU_MSUBU;
  - default latency constants;
  - counter width constant (8).
- One sub-module, `mdu_divider`: combinational signed/unsigned quotient and remainder. It also outputs a div-by-zero flag and applies the overflow rule.
- Top level holds the counter FSM, pending registers, HI/LO and the multiply/accumulate logic.

## Test plan
Defaults WIDTH=32, MULT_LAT=5, DIV_LAT=10.
- MULT d1=0xFFFFFFFF, d2=2 -> busy high 4 cycles; after edge t+5: hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV d1=0xFFFFFFF9 (−7), d2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF at t+10. DIV d1=0x80000000, d2=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload hi=0x11, lo=0x22 via hi_write/lo_write, then DIVU d2=0 -> busy for 9 cycles; hi=0x11, lo=0x22 after completion.
- DIV started, flush at cycle 3 -> busy=0 next cycle, HI/LO unchanged. A start asserted while busy is ignored and the assertion fires.
- MDU_MADD_EN defined: hi=0, lo=5, MADD 3,4 -> lo=17, hi=0. MSUBU 1,6 from hi=0, lo=5 -> {hi,lo}=0xFFFFFFFF_FFFFFFFF. With MDU_MADD_EN undefined, the same start -> no busy, HI/LO unchanged.
- Back-to-back MULT then DIV, with the second start in the cycle busy drops -> second result at t+5+10. reset asserted mid-run -> hi=lo=0, busy=0 next cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, default latencies, counter width.
// Optional multiply-accumulate ops (codes 4-7) are enabled by defining MDU_MADD_EN.
package mdu_pkg;

    localparam int unsigned MDU_OP_W  = 3;
    localparam int unsigned MDU_CNT_W = 8;

    localparam int unsigned MDU_MULT_LAT_DEF = 5;
    localparam int unsigned MDU_DIV_LAT_DEF  = 10;

    localparam logic [MDU_OP_W-1:0] MDU_MULT  = 3'd0;
    localparam logic [MDU_OP_W-1:0] MDU_MULTU = 3'd1;
    localparam logic [MDU_OP_W-1:0] MDU_DIV   = 3'd2;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 3'd3;
    localparam logic [MDU_OP_W-1:0] MDU_MADD  = 3'd4;
    localparam logic [MDU_OP_W-1:0] MDU_MADDU = 3'd5;
    localparam logic [MDU_OP_W-1:0] MDU_MSUB  = 3'd6;
    localparam logic [MDU_OP_W-1:0] MDU_MSUBU = 3'd7;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

    // Even op codes are the signed variants.
    function automatic logic mdu_is_signed(input logic [MDU_OP_W-1:0] code);
        return ~code[0];
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Combinational signed/unsigned divider: quotient truncates toward zero, remainder follows
// the dividend's sign; flags divide-by-zero and pins the min-int / -1 overflow result.
module mdu_divider
#(
    parameter int unsigned WIDTH = 32
)
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_zero
);

    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] b_safe;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;

    // Divide magnitudes, then restore signs.
    always_comb begin
        a_neg    = is_signed & a[WIDTH-1];
        b_neg    = is_signed & b[WIDTH-1];
        a_mag    = a_neg ? (~a + WIDTH'(1)) : a;
        b_mag    = b_neg ? (~b + WIDTH'(1)) : b;
        div_zero = (b == '0);
        b_safe   = div_zero ? WIDTH'(1) : b_mag;
        q_mag    = a_mag / b_safe;
        r_mag    = a_mag % b_safe;

        quot = (a_neg ^ b_neg) ? (~q_mag + WIDTH'(1)) : q_mag;
        rem  = a_neg ? (~r_mag + WIDTH'(1)) : r_mag;

        if (is_signed && (a == MIN_INT) && (b == '1)) begin
            quot = MIN_INT;
            rem  = '0;
        end
        if (div_zero) begin
            quot = '0;
            rem  = '0;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and flush; results are computed at
// acceptance and committed by a latency down-counter. MDU_MADD_EN enables MADD/MSUB ops.
module mult_div_unit
import mdu_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MULT_LAT = MDU_MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = MDU_DIV_LAT_DEF
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MDU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    d1,
    input  logic [WIDTH-1:0]    d2,
    input  logic                hi_write,
    input  logic                lo_write,
    input  logic                flush,
    output logic                busy,
    output logic [WIDTH-1:0]    hi,
    output logic [WIDTH-1:0]    lo
);

    localparam int unsigned PW = 2 * WIDTH;

    mdu_state_e           state_q;
    mdu_state_e           state_d;
    logic [MDU_CNT_W-1:0] cnt_q;
    logic [MDU_CNT_W-1:0] cnt_d;
    logic                 busy_d;
    logic [PW-1:0]        pend_q;
    logic                 pend_wr_q;

    logic                 op_valid;
    logic                 op_div;
    logic                 op_acc;
    logic                 op_signed;
    logic [MDU_CNT_W-1:0] lat_c;
    logic [PW-1:0]        a_ext;
    logic [PW-1:0]        b_ext;
    logic [PW-1:0]        prod_c;
    logic [PW-1:0]        acc_c;
    logic [PW-1:0]        res_c;
    logic                 res_wr_c;
    logic                 accept_c;
    logic                 commit_now_c;
    logic                 commit_pend_c;

    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     rem;
    logic                 div_zero;

    mdu_divider #(.WIDTH(WIDTH)) u_divider (
        .a         (d1),
        .b         (d2),
        .is_signed (op_signed),
        .quot      (quot),
        .rem       (rem),
        .div_zero  (div_zero)
    );

    // Op decode; accumulate codes are rejected when the feature is not built.
    always_comb begin
        op_valid  = 1'b1;
        op_div    = 1'b0;
        op_acc    = 1'b0;
        op_signed = mdu_is_signed(op);
        case (op)
            MDU_MULT, MDU_MULTU: op_div = 1'b0;
            MDU_DIV, MDU_DIVU:   op_div = 1'b1;
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: begin
`ifdef MDU_MADD_EN
                op_acc   = 1'b1;
`else
                op_valid = 1'b0;
`endif
            end
            default: op_valid = 1'b0;
        endcase
        lat_c = op_div ? MDU_CNT_W'(DIV_LAT) : MDU_CNT_W'(MULT_LAT);
    end

    // Sign/zero extension to 2*WIDTH makes one truncated product serve both signednesses.
    always_comb begin
        a_ext  = op_signed ? {{WIDTH{d1[WIDTH-1]}}, d1} : {{WIDTH{1'b0}}, d1};
        b_ext  = op_signed ? {{WIDTH{d2[WIDTH-1]}}, d2} : {{WIDTH{1'b0}}, d2};
        prod_c = a_ext * b_ext;
    end

`ifdef MDU_MADD_EN
    // Accumulate base is the HI/LO value in the start cycle; the sum wraps.
    always_comb begin
        if ((op == MDU_MSUB) || (op == MDU_MSUBU)) begin
            acc_c = {hi, lo} - prod_c;
        end else begin
            acc_c = {hi, lo} + prod_c;
        end
    end
`else
    assign acc_c = '0;
`endif

    always_comb begin
        res_wr_c = 1'b1;
        if (op_acc) begin
            res_c = acc_c;
        end else if (op_div) begin
            res_c    = {rem, quot};
            res_wr_c = ~div_zero;
        end else begin
            res_c = prod_c;
        end
    end

    // Counter FSM: next state and control strobes.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        accept_c      = 1'b0;
        commit_now_c  = 1'b0;
        commit_pend_c = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                if (start && !flush && op_valid) begin
                    accept_c = 1'b1;
                    if (lat_c <= MDU_CNT_W'(1)) begin
                        commit_now_c = res_wr_c;
                    end else begin
                        state_d = MDU_RUN;
                        cnt_d   = lat_c - MDU_CNT_W'(1);
                    end
                end
            end
            MDU_RUN: begin
                if (flush) begin
                    state_d = MDU_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == MDU_CNT_W'(1)) begin
                    commit_pend_c = pend_wr_q;
                    state_d       = MDU_IDLE;
                    cnt_d         = '0;
                end else begin
                    cnt_d = cnt_q - MDU_CNT_W'(1);
                end
            end
            default: begin
                state_d = MDU_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == MDU_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MDU_IDLE;
            cnt_q     <= '0;
            busy      <= 1'b0;
            pend_q    <= '0;
            pend_wr_q <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy    <= busy_d;

            if (accept_c) begin
                pend_q    <= res_c;
                pend_wr_q <= res_wr_c;
            end else if (flush) begin
                pend_q    <= '0;
                pend_wr_q <= 1'b0;
            end

            // Commit beats mthi/mtlo; a raw start also blocks them.
            if (commit_now_c) begin
                {hi, lo} <= res_c;
            end else if (commit_pend_c) begin
                {hi, lo} <= pend_q;
            end else if (!busy && !start) begin
                if (hi_write) hi <= d1;
                if (lo_write) lo <= d1;
            end
        end
    end

`ifndef SYNTHESIS
    // A start while busy is dropped; the hazard unit should have stalled it.
    start_while_busy_a: assert property (@(posedge clk) disable iff (reset) !(start && busy));
`endif

endmodule
